// File: rtl/cpu_mult_pipe.sv
// Pipelined signed/unsigned/mixed-sign multiplier returning the low or high product half; LATENCY cycles in to out.
// Backpressure: one global advance (!out_valid || out_ready) shifts every stage, and in_ready follows it combinationally.
// Optional accumulator behind `define CPU_MULT_PIPE_ACCUM_EN (adds in_acc/in_acc_clr and a 2*DATA_W running sum).
`timescale 1ns/1ps

module cpu_mult_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_sign_a,
    input  logic              in_sign_b,
    input  logic              in_hi,
    input  logic [TAG_W-1:0]  in_tag,
`ifdef CPU_MULT_PIPE_ACCUM_EN
    input  logic              in_acc,
    input  logic              in_acc_clr,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int SW = (DATA_W >= 32) ? 16 : DATA_W / 2;
    localparam int NS = DATA_W / SW;
    localparam int PW = SW + DATA_W;
    localparam int P2 = 2 * DATA_W;
    localparam int CW = DATA_W + 1;

    typedef struct packed {
        logic             hi;
        logic [TAG_W-1:0] tag;
`ifdef CPU_MULT_PIPE_ACCUM_EN
        logic             acc;
        logic             clr;
`endif
    } ctl_t;

    typedef logic [NS-1:0][PW-1:0] pp_t;

    // The (W+1)-bit signed product mod 2^2W equals the unsigned product minus
    // (b if a is negative) and (a if b is negative), both shifted up by W.
    function automatic logic [P2-1:0] sum_pp(input pp_t pp, input logic [CW-1:0] corr);
        logic [P2-1:0] s;
        s = '0;
        for (int i = 0; i < NS; i++)
            s = s + (P2'(pp[i]) << (i * SW));
        s = s - (P2'(corr) << DATA_W);
        return s;
    endfunction

    logic          advance;
    pp_t           pp_c;
    logic [CW-1:0] corr_c;
    ctl_t          ctl_in;

    logic          fin_vld;
    logic [P2-1:0] fin_prod;
    ctl_t          fin_ctl;
    logic [P2-1:0] new_sum;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        for (int i = 0; i < NS; i++)
            pp_c[i] = PW'(in_a[i*SW +: SW]) * PW'(in_b);
        corr_c = ((in_sign_a && in_a[DATA_W-1]) ? CW'(in_b) : '0)
               + ((in_sign_b && in_b[DATA_W-1]) ? CW'(in_a) : '0);
    end

    always_comb begin
        ctl_in     = '0;
        ctl_in.hi  = in_hi;
        ctl_in.tag = in_tag;
`ifdef CPU_MULT_PIPE_ACCUM_EN
        ctl_in.acc = in_acc;
        ctl_in.clr = in_acc_clr;
`endif
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign fin_vld  = in_valid;
            assign fin_prod = sum_pp(pp_c, corr_c);
            assign fin_ctl  = ctl_in;
        end else begin : g_latn
            logic          s1_vld;
            pp_t           s1_pp;
            logic [CW-1:0] s1_corr;
            ctl_t          s1_ctl;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_vld  <= 1'b0;
                    s1_pp   <= '0;
                    s1_corr <= '0;
                    s1_ctl  <= '0;
                end else if (advance) begin
                    s1_vld  <= in_valid;
                    s1_pp   <= pp_c;
                    s1_corr <= corr_c;
                    s1_ctl  <= ctl_in;
                end
            end

            if (LATENCY == 2) begin : g_direct
                assign fin_vld  = s1_vld;
                assign fin_prod = sum_pp(s1_pp, s1_corr);
                assign fin_ctl  = s1_ctl;
            end else begin : g_mid
                localparam int MD = LATENCY - 2;
                logic [MD-1:0]         mid_vld;
                logic [MD-1:0][P2-1:0] mid_prod;
                ctl_t [MD-1:0]         mid_ctl;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        mid_vld  <= '0;
                        mid_prod <= '0;
                        mid_ctl  <= '0;
                    end else if (advance) begin
                        mid_vld[0]  <= s1_vld;
                        mid_prod[0] <= sum_pp(s1_pp, s1_corr);
                        mid_ctl[0]  <= s1_ctl;
                        for (int k = 1; k < MD; k++) begin
                            mid_vld[k]  <= mid_vld[k-1];
                            mid_prod[k] <= mid_prod[k-1];
                            mid_ctl[k]  <= mid_ctl[k-1];
                        end
                    end
                end

                assign fin_vld  = mid_vld[MD-1];
                assign fin_prod = mid_prod[MD-1];
                assign fin_ctl  = mid_ctl[MD-1];
            end
        end
    endgenerate

`ifdef CPU_MULT_PIPE_ACCUM_EN
    logic [P2-1:0] acc_q;
    logic [P2-1:0] out_sum;
    logic [P2-1:0] acc_base;
    logic          out_acc;

    // The op leaving this cycle commits its sum in the same edge, so a
    // back-to-back accumulate must build on that sum rather than on acc_q.
    always_comb begin
        acc_base = (out_valid && out_ready && out_acc) ? out_sum : acc_q;
        new_sum  = fin_prod;
        if (fin_ctl.acc)
            new_sum = (fin_ctl.clr ? '0 : acc_base) + fin_prod;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            out_sum <= '0;
            out_acc <= 1'b0;
        end else begin
            if (out_valid && out_ready && out_acc)
                acc_q <= out_sum;
            if (advance) begin
                out_sum <= new_sum;
                out_acc <= fin_vld && fin_ctl.acc;
            end
        end
    end
`else
    assign new_sum = fin_prod;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (advance) begin
            out_valid  <= fin_vld;
            out_result <= fin_ctl.hi ? new_sum[P2-1:DATA_W] : new_sum[DATA_W-1:0];
            out_tag    <= fin_ctl.tag;
        end
    end

endmodule
